// File: rtl/tiny_rv_pkg.sv
// Shared opcode constants, format tags and the per-entry record for the tiny_rv decode queue.
package tiny_rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_ALUI     = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm32;
    fmt_e        fmt;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/tiny_rv_imm_gen.sv
// Combinational RV32I immediate/format decode with illegal-instruction detection.
module tiny_rv_imm_gen
  import tiny_rv_pkg::*;
#(
  parameter int unsigned RV32E = 0
) (
  input  logic [31:0] inst,
  output logic [31:0] imm32,
  output logic [2:0]  fmt,
  output logic        illegal
);

  logic [31:0] imm_raw;
  fmt_e        fmt_raw;
  logic        known;
  logic        use_rd, use_rs1, use_rs2;
  logic        reg_bad;

  always_comb begin
    imm_raw = 32'd0;
    fmt_raw = FMT_X;
    known   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_ALUI, OPC_JALR, OPC_SYSTEM: begin
        imm_raw = {{20{inst[31]}}, inst[31:20]};
        fmt_raw = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_MISC_MEM: begin
        fmt_raw = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt_raw = FMT_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt_raw = FMT_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_raw = {inst[31:12], 12'b0};
        fmt_raw = FMT_U;
        use_rd  = 1'b1;
      end
      OPC_JAL: begin
        imm_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt_raw = FMT_J;
        use_rd  = 1'b1;
      end
      OPC_OP: begin
        fmt_raw = FMT_R;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // RV32E only has x0..x15, so bit 4 of any register field the format reads is out of range.
  assign reg_bad = (RV32E != 0) &&
                   ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]));

  assign illegal = (inst[1:0] != 2'b11) || !known || reg_bad;
  assign imm32   = illegal ? 32'd0 : imm_raw;
  assign fmt     = illegal ? FMT_X : fmt_raw;

endmodule

// File: rtl/tiny_rv_decode_q.sv
// Decode stage with valid/ready handshake; decoded instructions are buffered in a DEPTH-entry queue.
module tiny_rv_decode_q
  import tiny_rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RV32E = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic [31:0] decode_pc,
  output logic [31:0] decode_inst,
  output logic [31:0] decode_imm32,
  output logic [6:0]  decode_opcode,
  output logic [2:0]  decode_funct3,
  output logic [6:0]  decode_funct7,
  output logic [4:0]  decode_rs1,
  output logic [4:0]  decode_rs2,
  output logic [4:0]  decode_rd,
  output logic [2:0]  decode_fmt,
  output logic        decode_illegal
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, clear;
  logic [31:0]   dec_imm;
  logic [2:0]    dec_fmt;
  logic          dec_ill;
  entry_t        head;

  tiny_rv_imm_gen #(
    .RV32E(RV32E)
  ) u_imm_gen (
    .inst   (fetch_inst),
    .imm32  (dec_imm),
    .fmt    (dec_fmt),
    .illegal(dec_ill)
  );

  assign clear        = i_reset || i_pipe_flush;
  assign fetch_ready  = (count != FullCount);
  assign decode_valid = (count != '0);
  assign push         = fetch_valid && fetch_ready;
  assign pop          = decode_valid && decode_ready;

  always_ff @(posedge i_clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: an empty queue masks the head to zero.
  always_ff @(posedge i_clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= '{pc: fetch_pc, inst: fetch_inst, imm32: dec_imm,
                       fmt: fmt_e'(dec_fmt), illegal: dec_ill};
    end
  end

  assign head = decode_valid ? mem[rd_ptr] : '0;

  always_comb begin
    decode_pc      = head.pc;
    decode_inst    = head.inst;
    decode_imm32   = head.imm32;
    decode_opcode  = head.inst[6:0];
    decode_rd      = head.inst[11:7];
    decode_funct3  = head.inst[14:12];
    decode_rs1     = head.inst[19:15];
    decode_rs2     = head.inst[24:20];
    decode_funct7  = head.inst[31:25];
    decode_fmt     = head.fmt;
    decode_illegal = head.illegal;
  end

endmodule
